// File: rtl/bt_tx_arbiter_if.sv
// Bundle of requester byte streams, the request-FIFO write port and the arbiter status outputs.
// The arbiter connects to the slave modport; the requesters and the FIFO drive the master side.
interface bt_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_vld;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_rdy;
  logic [7:0]           out_data;
  logic                 out_vld;
  logic                 out_rdy;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 frame_done;
  logic                 timeout_err;
  logic [CNT_W-1:0]     frame_cnt;

  modport master (
    output req_data, req_vld, req_last, out_rdy,
    input  req_rdy, out_data, out_vld, grant, busy, frame_done, timeout_err, frame_cnt
  );

  modport slave (
    input  req_data, req_vld, req_last, out_rdy,
    output req_rdy, out_data, out_vld, grant, busy, frame_done, timeout_err, frame_cnt
  );
endinterface

// File: rtl/bt_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one FIFO write port among NUM_REQ byte streams,
// with an optional ID header per frame and a watchdog that aborts frames stalled by their owner.
module bt_tx_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [3:0] HEADER_TAG  = 4'hA,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  bt_tx_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W:0]   NREQ     = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] gidx, gidx_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [WD_W-1:0]  wd, wd_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done, done_n;
  logic             tout, tout_n;

  logic [7:0]         req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   next_ptr;
  logic               found;
  logic               g_vld;
  logic               g_last;
  logic               beat;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = bus.req_data[8*i +: 8];
  end

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0; lowest set bit wins.
  always_comb begin
    rot   = NUM_REQ'({bus.req_vld, bus.req_vld} >> rr_ptr);
    found = |bus.req_vld;
    pick  = '0;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (sum >= NREQ) sum = sum - NREQ;
        pick = sum[IDX_W-1:0];
      end
    end
  end

  assign g_vld    = bus.req_vld[gidx];
  assign g_last   = bus.req_last[gidx];
  assign beat     = g_vld & bus.out_rdy;
  assign next_ptr = (gidx == LAST_IDX) ? '0 : gidx + IDX_W'(1);

  always_comb begin
    state_n      = state;
    gidx_n       = gidx;
    rr_ptr_n     = rr_ptr;
    wd_n         = wd;
    cnt_n        = cnt;
    done_n       = 1'b0;
    tout_n       = 1'b0;
    bus.out_data = '0;
    bus.out_vld  = 1'b0;
    bus.req_rdy  = '0;
    case (state)
      IDLE: begin
        wd_n = '0;
        if (found) begin
          gidx_n  = pick;
          state_n = HEADER_EN ? HEADER : DATA;
        end
      end
      HEADER: begin
        bus.out_vld  = 1'b1;
        bus.out_data = {HEADER_TAG, 4'(gidx)};
        if (bus.out_rdy) begin
          state_n = DATA;
          wd_n    = '0;
        end
      end
      DATA: begin
        bus.out_data      = req_byte[gidx];
        bus.out_vld       = g_vld;
        bus.req_rdy[gidx] = bus.out_rdy;
        if (beat) begin
          wd_n = '0;
          if (g_last) begin
            done_n   = 1'b1;
            cnt_n    = cnt + CNT_W'(1);
            rr_ptr_n = next_ptr;
            state_n  = IDLE;
          end
        end else if (!g_vld) begin
          // Only owner silence counts; FIFO backpressure with data pending holds the count.
          if (wd == WD_MAX) begin
            tout_n   = 1'b1;
            rr_ptr_n = next_ptr;
            state_n  = IDLE;
          end else begin
            wd_n = wd + WD_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gidx   <= '0;
      rr_ptr <= '0;
      wd     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      tout   <= 1'b0;
    end else begin
      state  <= state_n;
      gidx   <= gidx_n;
      rr_ptr <= rr_ptr_n;
      wd     <= wd_n;
      cnt    <= cnt_n;
      done   <= done_n;
      tout   <= tout_n;
    end
  end

  assign bus.grant       = (state == IDLE) ? '0 : (NUM_REQ'(1) << gidx);
  assign bus.busy        = (state != IDLE);
  assign bus.frame_done  = done;
  assign bus.timeout_err = tout;
  assign bus.frame_cnt   = cnt;
endmodule

// File: doc/bt_tx_arbiter.md
Name: bt_tx_arbiter

Overview:
- Round-robin arbiter that shares the single Bluetooth request-FIFO write port among NUM_REQ byte-stream requesters.
- Grants are held for a whole frame, so frames from different requesters never interleave; bytes pass straight through while a grant is held.
- Each frame can be prefixed with a header byte carrying the requester ID.
- A stall watchdog releases a grant held by a requester that stops sending mid-frame.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- HEADER_EN, 1, 1 = emit one header byte before each frame; 0 = no header.
- HEADER_TAG, 4'hA, upper nibble of the header byte.
- TIMEOUT_CYC, 1024, number of consecutive granted-but-idle cycles that aborts a frame; must be ≥ 1.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_data  in  NUM_REQ*8  requester i byte in bits [8i+7:8i].
- req_vld  in  NUM_REQ  requester byte valid.
- req_last  in  NUM_REQ  byte is the final byte of the frame.
- req_rdy  out  NUM_REQ  byte accepted by the arbiter.
- out_data  out  8  byte to the request FIFO data_i.
- out_vld  out  1  to the request FIFO data_i_vld.
- out_rdy  in  1  from the request FIFO data_i_rdy.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse on acceptance of a last byte.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- frame_cnt  out  CNT_W  count of completed frames; wraps to 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, grant=0, watchdog=0, frame_cnt=0.
  - frame_done=0, timeout_err=0, out_vld=0, out_data=0, req_rdy=0.
- States: IDLE, HEADER, DATA.
- IDLE:
  - out_vld=0, req_rdy=0.
  - If any req_vld is high, pick the first asserted index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register grant and go to HEADER (HEADER_EN=1) or DATA (HEADER_EN=0).
  - Latency: req_vld high at edge N gives out_vld=1 in the cycle after edge N+1 (one idle arbitration cycle).
- HEADER:
  - out_vld=1, out_data={HEADER_TAG, 4-bit granted index}, req_rdy=0.
  - On out_rdy=1 the header is accepted; go to DATA.
  - If out_rdy=0, hold out_data stable.
- DATA (combinational pass-through from granted requester g):
  - out_data=req_data[g], out_vld=req_vld[g], req_rdy[g]=out_rdy.
  - All other req_rdy bits are 0.
  - A beat is accepted when req_vld[g] & out_rdy.
  - Accepted beat with req_last[g]=1:
    - frame_done pulses next cycle; frame_cnt+1.
    - rr_ptr=(g+1) mod NUM_REQ; grant=0; go to IDLE.
- Watchdog:
  - Counts only in DATA, on cycles where req_vld[g]=0.
  - Clears on any accepted beat and on entry to DATA.
  - Cycles with req_vld[g]=1 and out_rdy=0 (FIFO backpressure) neither count nor clear.
  - When the count reaches TIMEOUT_CYC:
    - timeout_err pulses; go to IDLE; rr_ptr=(g+1) mod NUM_REQ.
    - frame_cnt is unchanged and no frame_done is issued.
    - Bytes already forwarded stay in the FIFO; no abort marker is sent.
- The watchdog does not run in HEADER; a full FIFO may stall the header indefinitely.
- A requester's req_last is ignored outside DATA.
- A frame of one byte (req_last on first byte) is legal.
- rr_ptr advances only at frame end or abort, never in IDLE. A lone requester therefore regains the grant after one IDLE cycle.
- frame_done and timeout_err never pulse in the same cycle.
- Reset mid-frame: outputs drop immediately (async); the partial frame in the FIFO is the system's responsibility.

Test Plan:
- Requester 2 sends 3-byte frame 0x11,0x22,0x33 (last on 0x33), out_rdy=1, HEADER_EN=1 → out bytes 0xA2,0x11,0x22,0x33 on consecutive cycles; frame_done pulses once; frame_cnt=1; grant=4'b0100 during frame.
- All 4 requesters hold 2-byte frames from reset → frames emitted in order 0,1,2,3, headers 0xA0..0xA3, no interleaving; requester 0 then re-requests and is served after 3.
- Backpressure: out_rdy toggles 1,0,0,1 during a frame → out_data held stable while out_rdy=0; no byte lost or duplicated; watchdog stays 0.
- TIMEOUT_CYC=8: requester 1 sends one non-last byte, then drops req_vld → timeout_err pulses exactly 8 cycles after the accepted byte; grant=0; next arbitration starts from index 2.
- Assert rst during DATA of requester 3 → grant, out_vld, busy are 0 in the same cycle; after release the first grant starts scanning from index 0.
- HEADER_EN=0, requester 0 sends a single byte 0x5A with last → out_vld in the cycle after arbitration, with no header; frame_done pulses.
